mem_arbiter: RTL

Parametrised N-channel arbiter that lets the fetch (IMEM) and memory-stage (DMEM) request streams, plus optional extra masters, share one unified single-port memory.
- Sits between the core's memory clients and the backing memory.
- Round-robin arbitration; one transaction in flight at a time.
- valid/ready request handshake per channel; one-cycle response pulse per channel.
- Supports variable memory latency, both loads and stores.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: client request/response channels plus the
// single-port memory side. The arbiter uses the slave view; the environment
// (clients + memory model) uses the master view.
interface mem_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // client side
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH*BE_W-1:0]   req_be;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic                     rsp_err;
  logic                     busy;

  // memory side
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [BE_W-1:0]          mem_be;
  logic                     mem_we;
  logic                     mem_rsp_valid;
  logic [DATA_W-1:0]        mem_rsp_data;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_be, req_we,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy,
    output mem_req_valid, mem_addr, mem_wdata, mem_be, mem_we
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_be, req_we,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
    input  mem_req_valid, mem_addr, mem_wdata, mem_be, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-channel arbiter in front of a single-port memory.
// One transaction in flight: IDLE (arbitrate/accept) -> ISSUE (hold memory
// request until accepted) -> WAIT (until memory completion) -> IDLE.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to terminate a transaction with
// rsp_err=1 after TIMEOUT_CYCLES cycles in ISSUE+WAIT.
module mem_arbiter #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  r_owner;
  logic [PTR_W-1:0]  w_winner;
  logic [PTR_W-1:0]  w_rr_next;
  logic              w_found;
  logic              w_accept;
  logic              w_tmo_hit;
  int unsigned       w_ptr_i;
  int unsigned       w_idx;

  logic [NUM_CH-1:0] w_req_ready;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [BE_W-1:0]   w_sel_be;
  logic              w_sel_we;

  logic [NUM_CH-1:0] r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;
  logic              r_mem_we;

  assign w_ptr_i = 32'(r_rr_ptr);

  // Round-robin search: first asserted request scanning from r_rr_ptr upward.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      w_idx = w_ptr_i + off;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (!w_found && (ch == w_idx) && bus.req_valid[ch]) begin
          w_found  = 1'b1;
          w_winner = PTR_W'(ch);
        end
      end
    end
  end

  // Pointer moves just past the winner so every channel gets a turn.
  always_comb begin
    w_rr_next = '0;
    if (32'(w_winner) != NUM_CH - 1) w_rr_next = w_winner + PTR_W'(1);
  end

  // Grant only in IDLE and never while reset is asserted.
  assign w_accept = reset && (r_state == IDLE) && w_found;

  // One-hot ready to the winner; payload mux of the winning channel.
  always_comb begin
    w_req_ready = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_we    = 1'b0;
    if (w_accept) w_req_ready[w_winner] = 1'b1;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (PTR_W'(ch) == w_winner) begin
        w_sel_addr  = bus.req_addr[ch*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata[ch*DATA_W +: DATA_W];
        w_sel_be    = bus.req_be[ch*BE_W +: BE_W];
        w_sel_we    = bus.req_we[ch];
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Watchdog counts cycles spent in ISSUE+WAIT; restarts on every accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != IDLE) && !w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_tmo_hit = (r_state != IDLE) && (32'(r_tmo_cnt) >= TIMEOUT_CYCLES - 1);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; a memory accept in ISSUE takes priority over timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ISSUE;
      ISSUE: begin
        if (bus.mem_req_ready) w_next_state = WAIT;
        else if (w_tmo_hit)    w_next_state = IDLE;
      end
      WAIT:    if (bus.mem_rsp_valid || w_tmo_hit) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: latch the winner's request, drive memory, return the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr        <= '0;
      r_owner         <= '0;
      r_rsp_valid     <= '0;
      r_rsp_data      <= '0;
      r_rsp_err       <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_be        <= '0;
      r_mem_we        <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mem_addr      <= w_sel_addr;
            r_mem_wdata     <= w_sel_wdata;
            r_mem_be        <= w_sel_be;
            r_mem_we        <= w_sel_we;
            r_owner         <= w_winner;
            r_rr_ptr        <= w_rr_next;
            r_mem_req_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
          end else if (w_tmo_hit) begin
            r_mem_req_valid      <= 1'b0;
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_err            <= 1'b1;
            r_rsp_data           <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_data           <= bus.mem_rsp_data;
            r_rsp_err            <= 1'b0;
          end else if (w_tmo_hit) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_err            <= 1'b1;
            r_rsp_data           <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.busy          = (r_state != IDLE);
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_be        = r_mem_be;
  assign bus.mem_we        = r_mem_we;
endmodule
